// File: rtl/arb_pkg.sv
// Shared state encodings, payload type and defaults for the two-port memory arbiter.
package arb_pkg;

   localparam int unsigned DATA_W           = 32;
   localparam int unsigned STATE_W          = 2;
   localparam int unsigned LOCK_MAX_DEFAULT = 16;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t IDLE = 2'b00;
   localparam state_t OWN0 = 2'b01;
   localparam state_t OWN1 = 2'b10;

   // Everything a requester presents to memory for one transfer.
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] adr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   localparam int unsigned MEM_REQ_W    = $bits(mem_req_t);
   localparam mem_req_t    MEM_REQ_NONE = '0;

   // Counter width able to hold 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_lock_timer.sv
// Counts consecutive locked grants of the current owner, saturating at LOCK_MAX.
// Only instantiated when the arbiter is built with ARB_TIMEOUT_EN.
module arb_lock_timer
   import arb_pkg::*;
#(
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CNT_W = cnt_width(LOCK_MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_max_c;

   assign at_max_c = (cnt_q == CNT_W'(LOCK_MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                  cnt_d = '0;
      else if (inc && !at_max_c) cnt_d = cnt_q + CNT_W'(1);
   end

   flopr #(.WIDTH(CNT_W)) u_cnt_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (cnt_d),
      .q       (cnt_q)
   );

   // High while a locked grant in progress is the LOCK_MAX-th in a row (or later).
   assign expired = (cnt_q >= CNT_W'(LOCK_MAX - 1));

endmodule

// File: rtl/flopenr.sv
// Load-enabled register with asynchronous active-low reset to zero.
module flopenr #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else if (en)  q <= d;
   end

endmodule

// File: rtl/flopr.sv
// Register with asynchronous active-low reset to zero.
module flopr #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= d;
   end

endmodule

// File: rtl/mux2.sv
// Two-input multiplexer; s selects d1.
module mux2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with round-robin tie-break and bus lock.
// Define ARB_TIMEOUT_EN to bound a locked owner to LOCK_MAX consecutive grants.
module mem_arbiter
   import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEFAULT
)
`endif
(
   input  logic        clk,
   input  logic        reset_n,

   input  logic        m0_req,
   input  logic        m0_lock,
   input  logic        m0_we,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic        m1_lock,
   input  logic        m1_we,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,

   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,

   output logic [1:0]  owner
);

   state_t   state_q;
   state_t   state_d;
   state_t   arb_next_c;
   logic     rr_q;
   logic     own0_c;
   logic     own1_c;
   logic     any_gnt_c;
   logic     pick_m1_c;
   logic     lock_expired;
   logic     m0_rd_c;
   logic     m1_rd_c;
   mem_req_t m0_pl;
   mem_req_t m1_pl;
   mem_req_t owner_pl;
   mem_req_t mem_pl;

   assign own0_c    = (state_q == OWN0);
   assign own1_c    = (state_q == OWN1);
   assign m0_gnt    = own0_c & m0_req;
   assign m1_gnt    = own1_c & m1_req;
   assign any_gnt_c = m0_gnt | m1_gnt;

   // rr_q=1 means M1 wins the next tie (M0 was served last).
   assign pick_m1_c = m1_req & (~m0_req | rr_q);

   always_comb begin
      arb_next_c = IDLE;
      if (m0_req | m1_req) arb_next_c = pick_m1_c ? OWN1 : OWN0;
   end

   // Next state: an owner keeps the bus while requesting unless it releases lock
   // (or its lock has expired) and the other side is waiting.
   always_comb begin
      state_d = arb_next_c;
      case (state_q)
         OWN0: if (m0_req) state_d = (m1_req && (!m0_lock || lock_expired)) ? OWN1 : OWN0;
         OWN1: if (m1_req) state_d = (m0_req && (!m1_lock || lock_expired)) ? OWN0 : OWN1;
         default: ;
      endcase
   end

   flopr #(.WIDTH(STATE_W)) u_state_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (state_d),
      .q       (state_q)
   );

   flopenr #(.WIDTH(1)) u_rr_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (any_gnt_c),
      .d       (m0_gnt),
      .q       (rr_q)
   );

`ifdef ARB_TIMEOUT_EN
   logic locked_gnt_c;
   logic tmr_clr_c;

   assign locked_gnt_c = (m0_gnt & m0_lock) | (m1_gnt & m1_lock);
   assign tmr_clr_c    = (any_gnt_c & ~locked_gnt_c) | (state_d != state_q);

   arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (tmr_clr_c),
      .inc     (locked_gnt_c),
      .expired (lock_expired)
   );
`else
   assign lock_expired = 1'b0;
`endif

   assign m0_pl = '{we: m0_we, adr: m0_adr, wdata: m0_wdata};
   assign m1_pl = '{we: m1_we, adr: m1_adr, wdata: m1_wdata};

   mux2 #(.WIDTH(MEM_REQ_W)) u_owner_mux (
      .d0 (m0_pl),
      .d1 (m1_pl),
      .s  (own1_c),
      .y  (owner_pl)
   );

   // Memory bus is quiet in IDLE; the strobe additionally needs a live grant.
   mux2 #(.WIDTH(MEM_REQ_W)) u_idle_mux (
      .d0 (MEM_REQ_NONE),
      .d1 (owner_pl),
      .s  (own0_c | own1_c),
      .y  (mem_pl)
   );

   assign mem_we    = any_gnt_c & mem_pl.we;
   assign mem_adr   = mem_pl.adr;
   assign mem_wdata = mem_pl.wdata;

   assign m0_rd_c = m0_gnt & ~m0_we;
   assign m1_rd_c = m1_gnt & ~m1_we;

   flopr #(.WIDTH(1)) u_m0_rvalid_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (m0_rd_c),
      .q       (m0_rvalid)
   );

   flopr #(.WIDTH(1)) u_m1_rvalid_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (m1_rd_c),
      .q       (m1_rvalid)
   );

   flopenr #(.WIDTH(DATA_W)) u_m0_rdata_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (m0_rd_c),
      .d       (mem_rdata),
      .q       (m0_rdata)
   );

   flopenr #(.WIDTH(DATA_W)) u_m1_rdata_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (m1_rd_c),
      .d       (mem_rdata),
      .q       (m1_rdata)
   );

   assign owner = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus reset, lock and mid-transfer reset sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_req, m0_lock, m0_we;
   logic [31:0] m0_adr, m0_wdata;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_lock, m1_we;
   logic [31:0] m1_adr, m1_wdata;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rdata;
   logic        mem_we;
   logic [31:0] mem_adr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m0_req    (m0_req),
      .m0_lock   (m0_lock),
      .m0_we     (m0_we),
      .m0_adr    (m0_adr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_lock   (m1_lock),
      .m1_we     (m1_we),
      .m1_adr    (m1_adr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   // One clock of stimulus: {req,lock,we} per port, memory read data, and expected outputs.
   typedef struct {
      logic [2:0]  c0;
      logic [31:0] a0, d0;
      logic [2:0]  c1;
      logic [31:0] a1, d1;
      logic [31:0] rd;
      logic [2:0]  eg;     // {m0_gnt, m1_gnt, mem_we}
      logic [31:0] eadr, ewd;
      logic [1:0]  ev;     // {m0_rvalid, m1_rvalid}
      logic [31:0] eq0, eq1;
      logic [1:0]  eown;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vec [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdata = '0;
      mem_rdata = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      tick();
      tick();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  n0, exp_n0, bad;
      logic seen;

      vec[0]  = '{3'b100, 32'h100, 32'hA000_0000, 3'b100, 32'h200, 32'hB000_0000, 32'hD000_0000, 3'b000, 32'h000, 32'h0000_0000, 2'b00, 32'h0000_0000, 32'h0000_0000, 2'd0};
      vec[1]  = '{3'b100, 32'h100, 32'hA000_0001, 3'b100, 32'h200, 32'hB000_0001, 32'hD000_0001, 3'b100, 32'h100, 32'hA000_0001, 2'b00, 32'h0000_0000, 32'h0000_0000, 2'd1};
      vec[2]  = '{3'b100, 32'h104, 32'hA000_0002, 3'b100, 32'h204, 32'hB000_0002, 32'hD000_0002, 3'b010, 32'h204, 32'hB000_0002, 2'b10, 32'hD000_0001, 32'h0000_0000, 2'd2};
      vec[3]  = '{3'b101, 32'h108, 32'hCAFE_0003, 3'b100, 32'h208, 32'hB000_0003, 32'hD000_0003, 3'b101, 32'h108, 32'hCAFE_0003, 2'b01, 32'hD000_0001, 32'hD000_0002, 2'd1};
      vec[4]  = '{3'b100, 32'h10C, 32'hA000_0004, 3'b101, 32'h020, 32'h1234_5678, 32'hD000_0004, 3'b011, 32'h020, 32'h1234_5678, 2'b00, 32'hD000_0001, 32'hD000_0002, 2'd2};
      vec[5]  = '{3'b100, 32'h10C, 32'hA000_0005, 3'b100, 32'h20C, 32'hB000_0005, 32'hD000_0005, 3'b100, 32'h10C, 32'hA000_0005, 2'b00, 32'hD000_0001, 32'hD000_0002, 2'd1};
      vec[6]  = '{3'b100, 32'h110, 32'hA000_0006, 3'b100, 32'h210, 32'hB000_0006, 32'hD000_0006, 3'b010, 32'h210, 32'hB000_0006, 2'b10, 32'hD000_0005, 32'hD000_0002, 2'd2};
      vec[7]  = '{3'b000, 32'h110, 32'h0000_0000, 3'b000, 32'h210, 32'h0000_0000, 32'hD000_0007, 3'b000, 32'h000, 32'h0000_0000, 2'b01, 32'hD000_0005, 32'hD000_0006, 2'd1};
      vec[8]  = '{3'b000, 32'h000, 32'h0000_0000, 3'b100, 32'h300, 32'hB000_0008, 32'hD000_0008, 3'b000, 32'h000, 32'h0000_0000, 2'b00, 32'hD000_0005, 32'hD000_0006, 2'd0};
      vec[9]  = '{3'b000, 32'h000, 32'h0000_0000, 3'b100, 32'h300, 32'hB000_0009, 32'hD000_0009, 3'b010, 32'h300, 32'hB000_0009, 2'b00, 32'hD000_0005, 32'hD000_0006, 2'd2};
      vec[10] = '{3'b100, 32'h400, 32'hA000_000A, 3'b000, 32'h300, 32'h0000_0000, 32'hD000_000A, 3'b000, 32'h000, 32'h0000_0000, 2'b01, 32'hD000_0005, 32'hD000_0009, 2'd2};
      vec[11] = '{3'b100, 32'h400, 32'hA000_000B, 3'b000, 32'h000, 32'h0000_0000, 32'hD000_000B, 3'b100, 32'h400, 32'hA000_000B, 2'b00, 32'hD000_0005, 32'hD000_0009, 2'd1};
      vec[12] = '{3'b000, 32'h000, 32'h0000_0000, 3'b000, 32'h000, 32'h0000_0000, 32'hD000_000C, 3'b000, 32'h000, 32'h0000_0000, 2'b10, 32'hD000_000B, 32'hD000_0009, 2'd1};
      vec[13] = '{3'b100, 32'h500, 32'hA000_000D, 3'b100, 32'h600, 32'hB000_000D, 32'hD000_000D, 3'b000, 32'h000, 32'h0000_0000, 2'b00, 32'hD000_000B, 32'hD000_0009, 2'd0};
      vec[14] = '{3'b100, 32'h500, 32'hA000_000E, 3'b100, 32'h600, 32'hB000_000E, 32'hD000_000E, 3'b010, 32'h600, 32'hB000_000E, 2'b00, 32'hD000_000B, 32'hD000_0009, 2'd2};

      // Reset values.
      do_reset();
      #2;
      check("reset owner",     32'(owner),     32'd0);
      check("reset m0_rvalid", 32'(m0_rvalid), 32'd0);
      check("reset m1_rvalid", 32'(m1_rvalid), 32'd0);
      check("reset m0_rdata",  m0_rdata,       32'h0);
      check("reset m1_rdata",  m1_rdata,       32'h0);
      check("reset gnt/we",    32'({m0_gnt, m1_gnt, mem_we}), 32'd0);

      // Read straight out of reset: gnt in cycle 2, data in cycle 3.
      tick();
      m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h10; mem_rdata = 32'hDEAD_BEEF;
      reset_n = 1'b1;
      #2;
      check("rel c1 gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
      tick(); #2;
      check("rel c2 m0_gnt",  32'(m0_gnt), 32'd1);
      check("rel c2 mem_adr", mem_adr,     32'h10);
      check("rel c2 mem_we",  32'(mem_we), 32'd0);
      tick();
      m0_req = 1'b0;
      #2;
      check("rel c3 m0_rvalid", 32'(m0_rvalid), 32'd1);
      check("rel c3 m0_rdata",  m0_rdata,       32'hDEAD_BEEF);
      tick(); #2;
      check("rel c4 m0_rvalid", 32'(m0_rvalid), 32'd0);
      check("rel c4 rdata hold", m0_rdata,      32'hDEAD_BEEF);

      // Vector table, row 0 is the first cycle after reset release.
      do_reset();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         if (i > 0) tick();
         {m0_req, m0_lock, m0_we} = vec[i].c0; m0_adr = vec[i].a0; m0_wdata = vec[i].d0;
         {m1_req, m1_lock, m1_we} = vec[i].c1; m1_adr = vec[i].a1; m1_wdata = vec[i].d1;
         mem_rdata = vec[i].rd;
         #2;
         check($sformatf("row%0d gnt0/gnt1/we", i), 32'({m0_gnt, m1_gnt, mem_we}), 32'(vec[i].eg));
         check($sformatf("row%0d rvalid", i), 32'({m0_rvalid, m1_rvalid}), 32'(vec[i].ev));
         check($sformatf("row%0d m0_rdata", i), m0_rdata, vec[i].eq0);
         check($sformatf("row%0d m1_rdata", i), m1_rdata, vec[i].eq1);
         check($sformatf("row%0d owner", i), 32'(owner), 32'(vec[i].eown));
         if (vec[i].eg[2] || vec[i].eg[1] || vec[i].eown == 2'd0)
            check($sformatf("row%0d mem_adr", i), mem_adr, vec[i].eadr);
         if (vec[i].eg[2] || vec[i].eg[1])
            check($sformatf("row%0d mem_wdata", i), mem_wdata, vec[i].ewd);
      end

      // M0 holds lock for 20 transfers while M1 waits, then releases it.
      do_reset();
      tick();
      reset_n = 1'b1;
      m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40; m1_req = 1'b1; m1_adr = 32'h80;
      mem_rdata = 32'h5555_AAAA;
      n0 = 0; bad = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         m0_lock = (n0 < 20);
         #2;
         if (m0_gnt && m1_gnt) bad++;
         if (mem_we && !m0_gnt && !m1_gnt) bad++;
         if (m1_gnt) begin
            seen = 1'b1;
            break;
         end
         if (m0_gnt) n0++;
         tick();
      end
`ifdef ARB_TIMEOUT_EN
      exp_n0 = 16;
`else
      exp_n0 = 21;
`endif
      check("lock m1 granted",        32'(seen), 32'd1);
      check("lock m0 gnts before m1", 32'(n0),   32'(exp_n0));
      check("lock gnt exclusivity",   32'(bad),  32'd0);

      // Reset asserted in the cycle after an M0 read grant.
      do_reset();
      tick();
      reset_n = 1'b1;
      m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h44; m1_req = 1'b1; m1_adr = 32'h88;
      mem_rdata = 32'h0BAD_F00D;
      #2;
      check("midrst c1 gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
      tick(); #2;
      check("midrst c2 m0_gnt", 32'(m0_gnt), 32'd1);
      tick();
      reset_n = 1'b0;
      #2;
      check("midrst m0_rvalid", 32'(m0_rvalid), 32'd0);
      check("midrst owner",     32'(owner),     32'd0);
      check("midrst m0_rdata",  m0_rdata,       32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      #2;
      check("midrst release gnt",   32'({m0_gnt, m1_gnt}), 32'd0);
      check("midrst release owner", 32'(owner),            32'd0);
      tick(); #2;
      check("midrst rr favours m0", 32'({m0_gnt, m1_gnt}), 32'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
